// File: rtl/bp_me_cce_mem_backing.sv
// Behavioural block-organised backing memory behind the CCE memory port: one outstanding
// command, fixed-latency response, storage zeroed by a sweep after every reset.
module bp_me_cce_mem_backing #(
    parameter int paddr_width_p     = 40,
    parameter int cce_block_width_p = 512,
    parameter int lce_id_width_p    = 4,
    parameter int lce_assoc_p       = 8,
    parameter int mem_els_p         = 1024,
    parameter int latency_p         = 4,
    localparam int msg_type_width_lp    = 4,
    localparam int size_width_lp        = 3,
    localparam int payload_width_lp     = lce_id_width_p + $clog2(lce_assoc_p),
    localparam int hdr_width_lp         = msg_type_width_lp + paddr_width_p + size_width_lp + payload_width_lp,
    localparam int cce_mem_msg_width_lp = hdr_width_lp + cce_block_width_p
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_yumi_i
);

    localparam int block_bytes_lp  = cce_block_width_p / 8;
    localparam int offset_width_lp = $clog2(block_bytes_lp);
    localparam int idx_width_lp    = $clog2(mem_els_p);
    localparam int cnt_width_lp    = (latency_p > 1) ? $clog2(latency_p) : 1;

    localparam logic [msg_type_width_lp-1:0] e_cce_mem_rd    = 4'd0;
    localparam logic [msg_type_width_lp-1:0] e_cce_mem_wr    = 4'd1;
    localparam logic [msg_type_width_lp-1:0] e_cce_mem_uc_rd = 4'd2;
    localparam logic [msg_type_width_lp-1:0] e_cce_mem_uc_wr = 4'd3;

    typedef enum logic [1:0] {e_clear, e_ready, e_wait, e_resp} state_e;

    state_e                         state_r, state_n;
    logic [idx_width_lp-1:0]        clear_idx_r;
    logic [cnt_width_lp-1:0]        cnt_r;
    logic [hdr_width_lp-1:0]        hdr_r;
    logic [cce_block_width_p-1:0]   data_r, data_n;
    logic [cce_block_width_p-1:0]   mem_r [mem_els_p];

    logic [hdr_width_lp-1:0]        cmd_hdr;
    logic [cce_block_width_p-1:0]   cmd_data;
    logic [msg_type_width_lp-1:0]   msg_type;
    logic [1:0]                     size_lg;
    logic [idx_width_lp-1:0]        idx;
    logic [offset_width_lp-1:0]     off;
    logic [cce_block_width_p-1:0]   blk;
    logic [7:0]                     size_mask;
    logic [block_bytes_lp-1:0]      byte_mask;
    logic [cce_block_width_p-1:0]   uc_merged;
    logic [cce_block_width_p-1:0]   uc_rdata;
    logic                           accept;
    logic                           mem_we;
    logic [idx_width_lp-1:0]        mem_widx;
    logic [cce_block_width_p-1:0]   mem_wdata;

    // Widen a per-byte enable into a per-bit mask over one block.
    function automatic logic [cce_block_width_p-1:0] expand_bytes(input logic [block_bytes_lp-1:0] m);
        logic [cce_block_width_p-1:0] r;
        for (int i = 0; i < block_bytes_lp; i++) begin
            r[8*i +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

    assign cmd_hdr  = mem_cmd_i[hdr_width_lp-1:0];
    assign cmd_data = mem_cmd_i[cce_mem_msg_width_lp-1 -: cce_block_width_p];
    assign msg_type = cmd_hdr[msg_type_width_lp-1:0];
    assign off      = cmd_hdr[msg_type_width_lp +: offset_width_lp];
    assign idx      = cmd_hdr[msg_type_width_lp + offset_width_lp +: idx_width_lp];
    assign size_lg  = cmd_hdr[msg_type_width_lp + paddr_width_p +: 2];
    assign blk      = mem_r[idx];
    assign accept   = (state_r == e_ready) && mem_cmd_v_i;

    // Uncached datapath: bytes shifted past the block end fall off, truncating the access.
    always_comb begin
        case (size_lg)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        byte_mask = {{(block_bytes_lp-8){1'b0}}, size_mask} << off;
        uc_merged = (blk & ~expand_bytes(byte_mask))
                  | ((cmd_data << {off, 3'b000}) & expand_bytes(byte_mask));
        uc_rdata  = (blk >> {off, 3'b000})
                  & expand_bytes({{(block_bytes_lp-8){1'b0}}, size_mask});
    end

    // Next state, storage write port and captured response data.
    always_comb begin
        state_n   = state_r;
        data_n    = data_r;
        mem_we    = 1'b0;
        mem_widx  = idx;
        mem_wdata = cmd_data;
        case (state_r)
            e_clear: begin
                mem_we    = 1'b1;
                mem_widx  = clear_idx_r;
                mem_wdata = '0;
                if (clear_idx_r == idx_width_lp'(mem_els_p - 1)) begin
                    state_n = e_ready;
                end else begin
                    state_n = e_clear;
                end
            end
            e_ready: begin
                if (mem_cmd_v_i) begin
                    state_n = (latency_p == 1) ? e_resp : e_wait;
                    case (msg_type)
                        e_cce_mem_rd:    data_n = blk;
                        e_cce_mem_wr:    begin data_n = '0; mem_we = 1'b1; end
                        e_cce_mem_uc_rd: data_n = uc_rdata;
                        e_cce_mem_uc_wr: begin data_n = '0; mem_we = 1'b1; mem_wdata = uc_merged; end
                        default:         data_n = '0;
                    endcase
                end else begin
                    state_n = e_ready;
                end
            end
            e_wait: begin
                if (cnt_r == cnt_width_lp'(1)) begin
                    state_n = e_resp;
                end else begin
                    state_n = e_wait;
                end
            end
            e_resp: begin
                if (mem_resp_yumi_i) begin
                    state_n = e_ready;
                end else begin
                    state_n = e_resp;
                end
            end
            default: state_n = e_clear;
        endcase
    end

    // Control and response registers; reset restarts the clearing sweep.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= e_clear;
            clear_idx_r <= '0;
            cnt_r       <= '0;
            hdr_r       <= '0;
            data_r      <= '0;
        end else begin
            state_r <= state_n;
            if (state_r == e_clear) begin
                clear_idx_r <= clear_idx_r + idx_width_lp'(1);
            end
            if (accept) begin
                cnt_r  <= cnt_width_lp'(latency_p - 1);
                hdr_r  <= cmd_hdr;
                data_r <= data_n;
            end else if (state_r == e_wait) begin
                cnt_r <= cnt_r - cnt_width_lp'(1);
            end
        end
    end

    // Block storage; writes commit on the accept edge.
    always_ff @(posedge clk_i) begin
        if (mem_we && !reset_i) begin
            mem_r[mem_widx] <= mem_wdata;
        end
    end

    assign mem_cmd_ready_o = (state_r == e_ready);
    assign mem_resp_v_o    = (state_r == e_resp);
    assign mem_resp_o      = {data_r, hdr_r};

endmodule

// File: tb/tb_bp_me_cce_mem_backing.sv
// Scoreboard bench for bp_me_cce_mem_backing: a byte-level reference memory predicts each
// response when the command is issued; responses are popped and compared as they appear.
module tb_bp_me_cce_mem_backing;

    localparam int PADDR = 40;
    localparam int BLK   = 512;
    localparam int ELS   = 1024;
    localparam int LAT   = 4;
    localparam int PAY   = 4 + 3;
    localparam int HDR   = 4 + PADDR + 3 + PAY;
    localparam int MSG   = HDR + BLK;
    localparam int BB    = BLK / 8;

    localparam logic [3:0] T_RD   = 4'd0;
    localparam logic [3:0] T_WR   = 4'd1;
    localparam logic [3:0] T_UCRD = 4'd2;
    localparam logic [3:0] T_UCWR = 4'd3;

    logic           clk = 1'b0;
    logic           reset_i = 1'b1;
    logic [MSG-1:0] mem_cmd_i = '0;
    logic           mem_cmd_v_i = 1'b0;
    logic           mem_cmd_ready_o;
    logic [MSG-1:0] mem_resp_o;
    logic           mem_resp_v_o;
    logic           mem_resp_yumi_i = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [BLK-1:0] ref_mem [ELS];
    logic [MSG-1:0] exp_q [$];

    bp_me_cce_mem_backing #(
        .paddr_width_p(PADDR), .cce_block_width_p(BLK), .lce_id_width_p(4),
        .lce_assoc_p(8), .mem_els_p(ELS), .latency_p(LAT)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_ready_o(mem_cmd_ready_o),
        .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_yumi_i(mem_resp_yumi_i)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [BLK-1:0] rand_blk();
        logic [BLK-1:0] r;
        for (int i = 0; i < BLK / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Reference: walks bytes individually, truncating at the block end.
    task automatic model(input logic [3:0] t, input logic [PADDR-1:0] addr, input logic [2:0] size,
                         input logic [BLK-1:0] data, output logic [BLK-1:0] rdata);
        int idx = int'(addr[15:6]);
        int off = int'(addr[5:0]);
        int nb  = 1 << size[1:0];
        logic [BLK-1:0] b = ref_mem[idx];
        rdata = '0;
        case (t)
            T_RD: rdata = b;
            T_WR: ref_mem[idx] = data;
            T_UCRD: for (int k = 0; k < nb; k++) if (off + k < BB) rdata[8*k +: 8] = b[8*(off+k) +: 8];
            T_UCWR: begin
                for (int k = 0; k < nb; k++) if (off + k < BB) b[8*(off+k) +: 8] = data[8*k +: 8];
                ref_mem[idx] = b;
            end
            default: rdata = '0;
        endcase
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!mem_cmd_ready_o && n < 2000) begin @(negedge clk); n++; end
        if (!mem_cmd_ready_o) begin
            miscompares++;
            $display("FAIL cmd_ready_wait: got ready=%0b after %0d cycles, required 1", mem_cmd_ready_o, n);
        end
    endtask

    task automatic do_txn(input logic [3:0] t, input logic [PADDR-1:0] addr, input logic [2:0] size,
                          input logic [BLK-1:0] data, input int hold);
        logic [HDR-1:0] hdr;
        logic [BLK-1:0] rdata;
        logic [MSG-1:0] exp, held;
        int lat = 1;
        hdr = {PAY'($urandom), size, addr, t};
        model(t, addr, size, data, rdata);
        exp_q.push_back({rdata, hdr});
        wait_ready();
        mem_cmd_i = {data, hdr};
        mem_cmd_v_i = 1'b1;
        @(negedge clk);
        mem_cmd_v_i = 1'b0;
        mem_cmd_i = ~{data, hdr};
        while (!mem_resp_v_o && lat < 100) begin @(negedge clk); lat++; end
        vectors++;
        if (lat !== LAT) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles, required %0d", lat, LAT);
        end
        exp = exp_q.pop_front();
        if (!mem_resp_v_o) return;
        vectors++;
        if (mem_resp_o !== exp) begin
            miscompares++;
            $display("FAIL resp t=%0h a=%h: got %h required %h", t, addr, mem_resp_o, exp);
        end
        held = mem_resp_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            vectors++;
            if (!mem_resp_v_o || mem_resp_o !== held || mem_cmd_ready_o) begin
                miscompares++;
                $display("FAIL backpressure cycle %0d: got v=%0b ready=%0b stable=%0b, required 1 0 1",
                         i, mem_resp_v_o, mem_cmd_ready_o, mem_resp_o === held);
            end
        end
        mem_resp_yumi_i = 1'b1;
        @(negedge clk);
        mem_resp_yumi_i = 1'b0;
        vectors++;
        if (!mem_cmd_ready_o || mem_resp_v_o) begin
            miscompares++;
            $display("FAIL after_yumi: got ready=%0b v=%0b, required 1 0", mem_cmd_ready_o, mem_resp_v_o);
        end
    endtask

    task automatic reset_dut(input int cycles);
        int n = 0;
        logic saw_v = 1'b0;
        reset_i = 1'b1;
        repeat (cycles) @(negedge clk);
        vectors++;
        if (mem_resp_v_o !== 1'b0 || mem_cmd_ready_o !== 1'b0 || mem_resp_o !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got v=%0b ready=%0b resp_nonzero=%0b, required 0 0 0",
                     mem_resp_v_o, mem_cmd_ready_o, mem_resp_o !== '0);
        end
        reset_i = 1'b0;
        while (!mem_cmd_ready_o && n < ELS + 50) begin
            @(negedge clk);
            n++;
            saw_v |= mem_resp_v_o;
        end
        vectors++;
        if (n !== ELS) begin
            miscompares++;
            $display("FAIL clear_cycles: got %0d, required %0d", n, ELS);
        end
        vectors++;
        if (saw_v) begin
            miscompares++;
            $display("FAIL resp_during_clear: got resp_v=1, required 0");
        end
        for (int i = 0; i < ELS; i++) ref_mem[i] = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_dut(3);
        do_txn(T_RD, 40'h0, 3'd6, '0, 0);
    endtask

    task automatic test_cached();
        do_txn(T_WR, 40'h80, 3'd6, {64{8'hA5}}, 0);
        do_txn(T_RD, 40'h80, 3'd6, '0, 0);
        do_txn(T_RD, 40'h85, 3'd6, '0, 0);
    endtask

    task automatic test_uncached();
        do_txn(T_WR,   40'h1000, 3'd6, rand_blk(), 0);
        do_txn(T_UCWR, 40'h1008, 3'd2, {{(BLK-32){1'b1}}, 32'hDEADBEEF}, 0);
        do_txn(T_UCRD, 40'h1008, 3'd2, rand_blk(), 0);
        do_txn(T_RD,   40'h1000, 3'd6, '0, 0);
        do_txn(T_UCRD, 40'h1009, 3'd0, '0, 0);
        do_txn(T_UCRD, 40'h100A, 3'd1, '0, 0);
        do_txn(T_WR,   40'h1040, 3'd6, rand_blk(), 0);
        do_txn(T_UCWR, 40'h103C, 3'd3, rand_blk(), 0);
        do_txn(T_UCRD, 40'h1038, 3'd3, '0, 0);
        do_txn(T_UCRD, 40'h103E, 3'd3, '0, 0);
        do_txn(T_RD,   40'h1040, 3'd6, '0, 0);
    endtask

    task automatic test_alias();
        do_txn(T_WR, 40'hC0, 3'd6, rand_blk(), 0);
        do_txn(T_RD, 40'hC0 + 40'(ELS * BB), 3'd6, '0, 0);
        do_txn(T_RD, 40'h80_0000_00C0, 3'd6, '0, 0);
    endtask

    task automatic test_backpressure();
        do_txn(T_RD, 40'h80, 3'd6, '0, 10);
        do_txn(T_UCRD, 40'h1008, 3'd2, '0, 3);
    endtask

    task automatic test_unknown();
        do_txn(4'h7, 40'h80, 3'd6, rand_blk(), 0);
        do_txn(T_RD, 40'h80, 3'd6, '0, 0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] t;
        logic [PADDR-1:0] a;
        for (int i = 0; i < 24; i++) begin
            t = 4'($urandom_range(0, 3));
            a = {24'($urandom), 10'($urandom_range(0, 3)), 6'($urandom)};
            do_txn(t, a, 3'($urandom_range(0, 3)), rand_blk(), 0);
        end
    endtask

    task automatic test_reset_mid();
        do_txn(T_WR, 40'h80, 3'd6, {64{8'h3C}}, 0);
        wait_ready();
        mem_cmd_i = {{BLK{1'b0}}, {PAY{1'b0}}, 3'd6, 40'h80, T_RD};
        mem_cmd_v_i = 1'b1;
        @(negedge clk);
        mem_cmd_v_i = 1'b0;
        reset_dut(1);
        do_txn(T_RD, 40'h80, 3'd6, '0, 0);
        do_txn(T_RD, 40'h1000, 3'd6, '0, 0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_cached();
        test_uncached();
        test_alias();
        test_backpressure();
        test_unknown();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bp_me_cce_mem_backing.md
Name: bp_me_cce_mem_backing

Overview:
- Behavioural backing memory that sits directly downstream of the CCE's memory interface.
- Consumes CCE memory commands (cached/uncached reads and writes) and produces the matching memory responses after a fixed latency.
- Used in CCE unit benches and single-core sims in place of the DRAM/L2 path.
- Handles one outstanding transaction; storage is block-organised and zeroed after reset.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p and the cce_mem message widths.
- mem_els_p, 1024, number of cce_block_width_p-bit blocks stored; power of two.
- latency_p, 4, cycles from command accept to response valid; must be >= 1.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  reset.
- mem_cmd_i  input  cce_mem_msg_width_lp  command message: header {msg_type, addr, size, payload} plus data.
- mem_cmd_v_i  input  1  command valid; ready->valid, asserted only while mem_cmd_ready_o=1.
- mem_cmd_ready_o  output  1  block can accept a command this cycle.
- mem_resp_o  output  cce_mem_msg_width_lp  response message.
- mem_resp_v_o  output  1  response valid; held until yumi.
- mem_resp_yumi_i  input  1  consumer takes the response this cycle; only while mem_resp_v_o=1.

Behaviour:
- Clock and reset: single clock clk_i; reset_i is synchronous, active-high.
- Reset values: mem_cmd_ready_o=0, mem_resp_v_o=0, mem_resp_o=0, latency counter=0, clear index=0.
- e_clear (entered on reset):
  - Writes zero to block[clear_idx] each cycle and increments clear_idx.
  - After block mem_els_p-1 is written, goes to e_ready. Clearing takes exactly mem_els_p cycles after reset deasserts.
  - ready=0 throughout.
- e_ready:
  - ready=1.
  - On mem_cmd_v_i: latches the header, stores write data, performs any write, loads counter=latency_p-1, goes to e_wait. If latency_p=1, goes directly to e_resp.
- e_wait: counter decrements each cycle; at 0 goes to e_resp. Response valid exactly latency_p cycles after the accept edge.
- e_resp:
  - mem_resp_v_o=1; header is the echoed command header.
  - On mem_resp_yumi_i, goes to e_ready; the next command can be accepted the cycle after yumi. No same-cycle accept.
- Indexing:
  - Block index = addr[lg(cce_block_width_p/8) +: lg(mem_els_p)].
  - Upper address bits are ignored, so addresses alias modulo mem_els_p blocks.
  - Byte offset = addr low bits.
- Cached read (e_cce_mem_rd): returns the full block, aligned to the block base regardless of offset.
- Cached write/writeback (e_cce_mem_wr): overwrites the full block; response data=0.
- Uncached read (e_cce_mem_uc_rd):
  - size in {1,2,4,8} bytes.
  - Response data = block shifted right by offset*8, masked to size bytes; upper bits 0.
- Uncached write (e_cce_mem_uc_wr):
  - Merges the low size bytes of cmd data into the block at offset; other bytes unchanged.
  - Response data=0.
  - An access crossing the block end is truncated at the block end.
- Read-after-write: a read issued after a write's response returns the written data. Writes commit in the accept cycle.
- Unknown msg_type: no storage change; response returned with data=0.
- Reset mid-operation (any state):
  - Drops the outstanding transaction and deasserts mem_resp_v_o next cycle.
  - Restarts e_clear from index 0. Storage contents become zero.
- Response stability: mem_resp_o is stable while mem_resp_v_o=1 and yumi=0.

Test Plan:
- Reset, then count cycles until ready -> mem_cmd_ready_o rises exactly mem_els_p cycles after reset deasserts. A cached read of addr 0x0 then returns data all-zero.
- Cached write of 0xA5 pattern to addr 0x80, then cached read of 0x80 -> data matches the pattern, resp_v asserted latency_p cycles after each accept, header echoed.
- Uncached write size 4 of 0xDEADBEEF to block offset 8, then uncached read size 4 at the same address -> data 0xDEADBEEF. A cached read of that block shows only bytes 8..11 changed.
- Alias: write a block at index 3, read at addr + mem_els_p*block_bytes -> same data returned.
- Backpressure: hold yumi low 10 cycles during e_resp -> resp_v stays 1, resp_o unchanged, cmd_ready stays 0. After yumi, ready rises the next cycle.
- Assert reset during e_wait of an outstanding read -> no response appears, ready=0 for mem_els_p cycles, previously written data reads back 0.
